// File: rtl/pipe_pclk_rate_ctrl_if.sv
// Rate request and clock-enable status bundle for the PIPE rate controller.
interface pipe_pclk_rate_ctrl_if;
   logic [1:0] rate_req;
   logic       pclk_en;
   logic [1:0] rate_cur;
   logic       phystatus;
   logic       busy;
   logic       rate_err;

   modport master (
      output rate_req,
      input  pclk_en,
      input  rate_cur,
      input  phystatus,
      input  busy,
      input  rate_err
   );

   modport slave (
      input  rate_req,
      output pclk_en,
      output rate_cur,
      output phystatus,
      output busy,
      output rate_err
   );
endinterface

// File: rtl/pipe_pclk_rate_ctrl.sv
// PIPE rate controller: divides the 250 MHz clock into a per-rate enable strobe
// and sequences rate changes through a strobe-free settle window.
module pipe_pclk_rate_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input logic                   pclk_250mhz,
   input logic                   rst_n,
   pipe_pclk_rate_ctrl_if.slave  bus
);

   localparam int unsigned SETTLE_W = 8;
   localparam int unsigned RATE_W   = 2;
   localparam int unsigned DIV_W    = 2;

   localparam logic [RATE_W-1:0]   RATE_62M5   = 2'b00;
   localparam logic [RATE_W-1:0]   RATE_125M   = 2'b01;
   localparam logic [RATE_W-1:0]   RATE_RSVD   = 2'b11;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_SWITCH,
      ST_RESUME
   } state_t;

   state_t              state_q,     state_nxt;
   logic [DIV_W-1:0]    div_q,       div_nxt;
   logic [SETTLE_W-1:0] settle_q,    settle_nxt;
   logic [RATE_W-1:0]   tgt_q,       tgt_nxt;
   logic [RATE_W-1:0]   rate_cur_q,  rate_cur_nxt;
   logic                pclk_en_q,   pclk_en_nxt;
   logic                phystatus_q, phystatus_nxt;
   logic                busy_q,      busy_nxt;
   logic                rate_err_q,  rate_err_nxt;

   logic [DIV_W-1:0]    div_max_c;
   logic                div_wrap_c;
   logic                req_valid_c;

   // Terminal count of the divider for the rate currently in effect
   always_comb begin
      case (rate_cur_q)
         RATE_62M5: div_max_c = DIV_W'(3);
         RATE_125M: div_max_c = DIV_W'(1);
         default:   div_max_c = DIV_W'(0);
      endcase
   end

   assign div_wrap_c  = (div_q == div_max_c);
   assign req_valid_c = (bus.rate_req != RATE_RSVD) && (bus.rate_req != rate_cur_q);

   always_ff @(posedge pclk_250mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         div_q       <= '0;
         settle_q    <= '0;
         tgt_q       <= RATE_62M5;
         rate_cur_q  <= RATE_62M5;
         pclk_en_q   <= 1'b0;
         phystatus_q <= 1'b0;
         busy_q      <= 1'b0;
         rate_err_q  <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         div_q       <= div_nxt;
         settle_q    <= settle_nxt;
         tgt_q       <= tgt_nxt;
         rate_cur_q  <= rate_cur_nxt;
         pclk_en_q   <= pclk_en_nxt;
         phystatus_q <= phystatus_nxt;
         busy_q      <= busy_nxt;
         rate_err_q  <= rate_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      div_nxt       = div_q;
      settle_nxt    = settle_q;
      tgt_nxt       = tgt_q;
      rate_cur_nxt  = rate_cur_q;
      pclk_en_nxt   = 1'b0;
      phystatus_nxt = 1'b0;
      busy_nxt      = busy_q;
      rate_err_nxt  = (bus.rate_req == RATE_RSVD);

      case (state_q)
         ST_RUN: begin
            if (req_valid_c) begin
               // Accept edge: strobe is suppressed from here until the new rate's first wrap
               state_nxt  = ST_DRAIN;
               tgt_nxt    = bus.rate_req;
               busy_nxt   = 1'b1;
               settle_nxt = '0;
            end else begin
               busy_nxt    = 1'b0;
               pclk_en_nxt = div_wrap_c;
               div_nxt     = div_wrap_c ? DIV_W'(0) : DIV_W'(div_q + DIV_W'(1));
            end
         end
         ST_DRAIN: begin
            settle_nxt = SETTLE_W'(settle_q + SETTLE_W'(1));
            if (settle_q == SETTLE_LAST) begin
               state_nxt = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            rate_cur_nxt = tgt_q;
            div_nxt      = '0;
            state_nxt    = ST_RESUME;
         end
         ST_RESUME: begin
            pclk_en_nxt = div_wrap_c;
            div_nxt     = div_wrap_c ? DIV_W'(0) : DIV_W'(div_q + DIV_W'(1));
            if (div_wrap_c) begin
               phystatus_nxt = 1'b1;
               state_nxt     = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   assign bus.pclk_en   = pclk_en_q;
   assign bus.rate_cur  = rate_cur_q;
   assign bus.phystatus = phystatus_q;
   assign bus.busy      = busy_q;
   assign bus.rate_err  = rate_err_q;

endmodule

// File: tb/tb_pipe_pclk_rate_ctrl.sv
// Directed bench for pipe_pclk_rate_ctrl with SETTLE_CYCLES=8.
module tb_pipe_pclk_rate_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   pipe_pclk_rate_ctrl_if bus();

   pipe_pclk_rate_ctrl #(.SETTLE_CYCLES(8)) dut (
      .pclk_250mhz (clk),
      .rst_n       (rst_n),
      .bus         (bus)
   );

   // Observed vector: {pclk_en, phystatus, busy, rate_cur[1:0], rate_err}
   logic [5:0] obs;
   assign obs = {bus.pclk_en, bus.phystatus, bus.busy, bus.rate_cur, bus.rate_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] exp;
      rst_n = 1'b0;
      bus.rate_req = 2'b00;
      tick();
      tick();
      exp = 6'b000000;
      n_checks++;
      if (obs !== exp) $display("FAIL reset_hold: got %b want %b", obs, exp);
      else n_pass++;
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp = {(e % 4 == 0), 1'b0, 1'b0, 2'b00, 1'b0};
         n_checks++;
         if (obs !== exp) $display("FAIL reset_div4 E%0d: got %b want %b", e, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_rate_00_to_10();
      logic [5:0] exp;
      bus.rate_req = 2'b10;
      for (int e = 0; e <= 12; e++) begin
         tick();
         exp = {(e >= 10), (e == 10), (e <= 10), (e >= 9) ? 2'b10 : 2'b00, 1'b0};
         n_checks++;
         if (obs !== exp) $display("FAIL rate_00_to_10 E%0d: got %b want %b", e, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_rate_10_to_00();
      logic [5:0] exp;
      bus.rate_req = 2'b00;
      for (int e = 0; e <= 21; e++) begin
         tick();
         exp = {(e >= 13) && ((e - 13) % 4 == 0), (e == 13), (e <= 13),
                (e >= 9) ? 2'b00 : 2'b10, 1'b0};
         n_checks++;
         if (obs !== exp) $display("FAIL rate_10_to_00 E%0d: got %b want %b", e, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_reserved();
      logic [5:0] exp;
      bus.rate_req = 2'b11;
      for (int t = 1; t <= 8; t++) begin
         if (t == 6) bus.rate_req = 2'b00;
         tick();
         exp = {(t % 4 == 0), 1'b0, 1'b0, 2'b00, (t <= 5)};
         n_checks++;
         if (obs !== exp) $display("FAIL reserved t%0d: got %b want %b", t, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_busy_change();
      logic [5:0] exp;
      logic [1:0] rc;
      bus.rate_req = 2'b01;
      for (int e = 0; e <= 23; e++) begin
         if (e == 3) bus.rate_req = 2'b10;
         tick();
         rc = (e >= 21) ? 2'b10 : (e >= 9) ? 2'b01 : 2'b00;
         exp = {(e == 11) || (e >= 22), (e == 11) || (e == 22), (e <= 22), rc, 1'b0};
         n_checks++;
         if (obs !== exp) $display("FAIL busy_change E%0d: got %b want %b", e, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp;
      bus.rate_req = 2'b00;
      for (int e = 0; e <= 4; e++) begin
         tick();
         exp = {1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
         n_checks++;
         if (obs !== exp) $display("FAIL reset_mid_drain E%0d: got %b want %b", e, obs, exp);
         else n_pass++;
      end
      #1 rst_n = 1'b0;
      #1;
      exp = 6'b000000;
      n_checks++;
      if (obs !== exp) $display("FAIL reset_mid_async: got %b want %b", obs, exp);
      else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp = {(e % 4 == 0), 1'b0, 1'b0, 2'b00, 1'b0};
         n_checks++;
         if (obs !== exp) $display("FAIL reset_mid_after E%0d: got %b want %b", e, obs, exp);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus.rate_req = 2'b00;
      test_reset();
      test_rate_00_to_10();
      test_rate_10_to_00();
      test_reserved();
      test_busy_change();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
